// File: rtl/config_pkg.sv
// Shared types and constants for the configuration SRAM sequencer.
package config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } seq_state_e;

  localparam int unsigned WW_BITS      = 16;
  localparam int unsigned SET_CNT_BITS = 4;

endpackage

// File: rtl/config_piso.sv
// Parallel-load, MSB-first shift register feeding the chain's serial input.
module config_piso #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] par_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Load wins over shift; shifting back-fills zeros so the register idles at 0.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = par_i;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/config_sram_sequencer.sv
// Serializes host address/data words onto a config_sram_data chain and commits them.
module config_sram_sequencer
  import config_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned SET_CYCLES = 1
) (
  input  logic                 cclk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_data,
  output logic                 shift_enable,
  output logic                 shift_in,
  output logic                 config_set,
  output logic                 busy,
  output logic                 done,
  output logic [WW_BITS-1:0]   words_written
);

  localparam int unsigned L            = ADDR_BITS + DATA_BITS;
  localparam int unsigned BIT_CNT_BITS = $clog2(L);

  localparam logic [BIT_CNT_BITS-1:0] BIT_LAST = BIT_CNT_BITS'(L - 1);
  localparam logic [SET_CNT_BITS-1:0] SET_LAST = SET_CNT_BITS'(SET_CYCLES - 1);

  seq_state_e                state_q, state_d;
  logic [BIT_CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SET_CNT_BITS-1:0]   set_cnt_q, set_cnt_d;
  logic                      ready_q, ready_d;
  logic                      shift_en_q, shift_en_d;
  logic                      cfg_set_q, cfg_set_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [WW_BITS-1:0]        words_written_q, words_written_d;

  logic                      accept;
  logic                      piso_load;
  logic                      piso_shift;
  logic                      piso_msb;

  assign accept = req_valid & ready_q;

  config_piso #(
    .WIDTH (L)
  ) u_piso (
    .clk     (cclk),
    .rst_n   (rst),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .par_i   ({req_data, req_addr}),
    .msb_o   (piso_msb)
  );

  // Next-state, counters and registered-output precompute from the next state.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    set_cnt_d       = set_cnt_q;
    piso_load       = 1'b0;
    piso_shift      = 1'b0;
    shift_en_d      = 1'b0;
    cfg_set_d       = 1'b0;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    ready_d         = 1'b0;
    words_written_d = words_written_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          piso_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        piso_shift = 1'b1;
        bit_cnt_d  = bit_cnt_q + BIT_CNT_BITS'(1);
        if (bit_cnt_q == BIT_LAST) begin
          state_d   = ST_COMMIT;
          bit_cnt_d = '0;
          set_cnt_d = '0;
        end
      end
      ST_COMMIT: begin
        if (set_cnt_q == SET_LAST) begin
          set_cnt_d = '0;
          if (accept) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            piso_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          set_cnt_d = set_cnt_q + SET_CNT_BITS'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    shift_en_d = (state_d == ST_SHIFT);
    cfg_set_d  = (state_d == ST_COMMIT);
    busy_d     = shift_en_d | cfg_set_d;
    done_d     = cfg_set_d && (set_cnt_d == SET_LAST);
    ready_d    = (state_d == ST_IDLE) || done_d;
    if (done_d && (words_written_q != '1)) begin
      words_written_d = words_written_q + WW_BITS'(1);
    end
  end

  // State, counters and registered outputs; reset drops every output at once.
  always_ff @(posedge cclk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      set_cnt_q       <= '0;
      ready_q         <= 1'b0;
      shift_en_q      <= 1'b0;
      cfg_set_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      set_cnt_q       <= set_cnt_d;
      ready_q         <= ready_d;
      shift_en_q      <= shift_en_d;
      cfg_set_q       <= cfg_set_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      words_written_q <= words_written_d;
    end
  end

  assign req_ready     = ready_q;
  assign shift_enable  = shift_en_q;
  assign shift_in      = shift_en_q & piso_msb;
  assign config_set    = cfg_set_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = words_written_q;

endmodule
